push_counter_bank: RTL and testbench
====================================

Name: push_counter_bank

Overview:
- Multi-channel push-event counter. Keeps one counter and one last-data register per channel.
- Returns any channel's count through a single req/idx read port with a one-cycle valid pulse.
- Next generation of the single-channel push counter. Adds N channels, selectable count mode, wrap or saturate, clear-on-read, and sticky overflow flags.
- Sits beside the FIFO/buffer push paths and is read by the statistics/test controller.

Parameters:
- DATA_WIDTH, 8, width of each channel's data word.
- NUM_CH, 4, number of channels (1..16).
- CH_SEL_WIDTH, 2, width of idx; must satisfy 2**CH_SEL_WIDTH >= NUM_CH.
- CNT_WIDTH, 8, counter width per channel.
- COUNT_MODE, 1, selects what counts as an event: 0 = every push, 1 = only pushes whose data differs from that channel's previous pushed word.
- SATURATE, 0, overflow handling: 0 = counter wraps to 0, 1 = counter holds at max.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  NUM_CH  per-channel push strobe.
- data_in  in  NUM_CH*DATA_WIDTH  channel c data is bits [c*DATA_WIDTH +: DATA_WIDTH].
- req  in  1  read request, one cycle per request.
- idx  in  CH_SEL_WIDTH  channel to read.
- clr_on_rd  in  1  when high with req, the selected counter is cleared.
- valid_cont  out  1  read-data valid pulse.
- data_cont  out  CNT_WIDTH  count returned by the read.
- ch_cont  out  CH_SEL_WIDTH  echo of the idx that was read.
- rd_err  out  1  high with valid_cont when idx >= NUM_CH.
- overflow  out  NUM_CH  sticky overflow flag per channel.

Behaviour:
- Reset: synchronous, active-high reset; clock clk. Reset wins over all other inputs in the same cycle.
  - Outputs after reset: valid_cont=0, data_cont=0, ch_cont=0, rd_err=0, overflow=0.
  - Internal state after reset: all counters=0, all data_ant=0, all first_seen=0.
  - Reset asserted mid-read cancels that read's valid pulse.
- Event detection, per channel c, in a cycle with push[c]=1:
  - COUNT_MODE=0: every push is an event.
  - COUNT_MODE=1: a push is an event if first_seen[c]=0 or data_in_c != data_ant[c]. The first push after reset always counts.
  - Every push updates data_ant[c] <= data_in_c and sets first_seen[c] <= 1.
  - No push means no change to that channel.
- Increment on an event:
  - Below max: cnt[c] <= cnt[c]+1.
  - At max (all ones), SATURATE=0: cnt[c] <= 0 and overflow[c] <= 1.
  - At max (all ones), SATURATE=1: cnt[c] holds and overflow[c] <= 1.
- Channels are independent. All NUM_CH channels may push and count in the same cycle.
- Read path:
  - req=1 at edge N gives valid_cont=1 for exactly the cycle after edge N. valid_cont is 0 whenever there was no req.
  - data_cont returns the pre-update count sampled at edge N. A same-cycle increment is not included.
  - ch_cont <= idx.
  - data_cont and ch_cont hold their last values when valid_cont=0.
  - idx >= NUM_CH: data_cont=0, rd_err=1, no state change.
  - Back-to-back reqs are legal and give one valid pulse per req.
- Clear-on-read (req=1, clr_on_rd=1, idx valid):
  - The selected counter becomes 0, or 1 if the same cycle also carries an event on that channel.
  - overflow[idx] clears unless the same cycle's event overflows again, in which case it stays 1.
  - data_ant and first_seen are not affected.
- No combinational paths from inputs to outputs.

Decomposition:
- Shared package push_counter_pkg holds:
  - localparams COUNT_ALL=0 and COUNT_CHANGE=1 for COUNT_MODE.
  - localparams MODE_WRAP=0 and MODE_SAT=1 for SATURATE.
  - The function clog2 for deriving CH_SEL_WIDTH.
- One sub-module, push_channel_counter, instantiated NUM_CH times in a generate loop. Each instance holds:
  - data_ant, first_seen, the counter and its overflow flag.
  - Inputs push, data, clr and max-detect.
- The top module keeps only the read mux and the output registers.

Test Plan:
- Reset, then push ch0 with data 0x00, 0x00, 0x05, 0x05, 0x07 (COUNT_MODE=1) -> read ch0 gives valid_cont=1 one cycle after req, data_cont=3. The first push counts even though it equals the reset value.
- COUNT_MODE=0, push all 4 channels together for 10 cycles -> read each channel gives data_cont=10, ch_cont = that channel.
- SATURATE=0, CNT_WIDTH=8, 256 distinct pushes on ch2 -> data_cont=0, overflow=4'b0100. Repeat with SATURATE=1 -> data_cont=255, overflow[2]=1.
- Counter ch1=4, then req+clr_on_rd with idx=1 in the same cycle as a counting push -> data_cont=4, and a following plain read returns 1.
- req with idx=5 when NUM_CH=4 -> valid_cont=1, rd_err=1, data_cont=0, counters unchanged.
- Reset asserted in the cycle after a req, with ch3=7 -> valid_cont=0, and a later read of ch3 returns 0.

Source files
------------

// File: rtl/push_counter_pkg.sv
// rtl/push_counter_pkg.sv - shared constants and helpers for the push counter bank
package push_counter_pkg;

    localparam int COUNT_ALL    = 0;
    localparam int COUNT_CHANGE = 1;
    localparam int MODE_WRAP    = 0;
    localparam int MODE_SAT     = 1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/push_channel_counter.sv
// rtl/push_channel_counter.sv - one channel: event detect, counter and sticky overflow
module push_channel_counter
    import push_counter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int COUNT_MODE = 1,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  clr,
    output logic [CNT_WIDTH-1:0]  cnt,
    output logic                  overflow
);

    logic [DATA_WIDTH-1:0] data_ant;
    logic                  first_seen;
    logic                  evt;
    logic                  at_max;
    logic                  count_changes;

    assign count_changes = (COUNT_MODE == COUNT_CHANGE);
    assign at_max        = &cnt;
    // The first push after reset counts even if it matches the reset value of data_ant.
    assign evt = push && (!count_changes || !first_seen || (data != data_ant));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            overflow   <= 1'b0;
            data_ant   <= '0;
            first_seen <= 1'b0;
        end else begin
            if (push) begin
                data_ant   <= data;
                first_seen <= 1'b1;
            end
            // Clear-on-read: the read already captured the old count, a same-cycle event lands on zero.
            if (clr) begin
                cnt      <= evt ? CNT_WIDTH'(1) : '0;
                overflow <= evt && at_max;
            end else if (evt) begin
                if (!at_max) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    overflow <= 1'b1;
                    if (SATURATE == MODE_WRAP) begin
                        cnt <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/push_counter_bank.sv
// rtl/push_counter_bank.sv - multi-channel push event counter with a registered read port
module push_counter_bank
    import push_counter_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CH       = 4,
    parameter int CH_SEL_WIDTH = 2,
    parameter int CNT_WIDTH    = 8,
    parameter int COUNT_MODE   = 1,
    parameter int SATURATE     = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            push,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic                         req,
    input  logic [CH_SEL_WIDTH-1:0]      idx,
    input  logic                         clr_on_rd,
    output logic                         valid_cont,
    output logic [CNT_WIDTH-1:0]         data_cont,
    output logic [CH_SEL_WIDTH-1:0]      ch_cont,
    output logic                         rd_err,
    output logic [NUM_CH-1:0]            overflow
);

    logic [CNT_WIDTH-1:0] cnt [NUM_CH];
    logic [CNT_WIDTH-1:0] rd_cnt;
    logic                 idx_ok;

    assign idx_ok = (32'(idx) < NUM_CH);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        push_channel_counter #(
            .DATA_WIDTH (DATA_WIDTH),
            .CNT_WIDTH  (CNT_WIDTH),
            .COUNT_MODE (COUNT_MODE),
            .SATURATE   (SATURATE)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .push     (push[c]),
            .data     (data_in[c*DATA_WIDTH +: DATA_WIDTH]),
            .clr      (req && clr_on_rd && (idx == CH_SEL_WIDTH'(c))),
            .cnt      (cnt[c]),
            .overflow (overflow[c])
        );
    end

    always_comb begin
        rd_cnt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (idx == CH_SEL_WIDTH'(c)) begin
                rd_cnt = cnt[c];
            end
        end
    end

    // Read returns the count as it stood before this edge's update.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_cont <= 1'b0;
            data_cont  <= '0;
            ch_cont    <= '0;
            rd_err     <= 1'b0;
        end else begin
            valid_cont <= req;
            rd_err     <= req && !idx_ok;
            if (req) begin
                ch_cont   <= idx;
                data_cont <= idx_ok ? rd_cnt : '0;
            end
        end
    end

endmodule

// File: tb/tb_push_counter_bank.sv
// tb/tb_push_counter_bank.sv - directed self-checking bench for push_counter_bank
module tb_push_counter_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  push;
    logic [31:0] data_in;
    logic        req;
    logic [2:0]  idx;
    logic        clr_on_rd;

    logic       a_valid, b_valid, s_valid;
    logic [7:0] a_data, b_data, s_data;
    logic [2:0] a_ch;
    logic [1:0] b_ch, s_ch;
    logic       a_err, b_err, s_err;
    logic [3:0] a_ovf, b_ovf, s_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    push_counter_bank #(.CH_SEL_WIDTH(3), .COUNT_MODE(1), .SATURATE(0)) dut_a (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .req(req),
        .idx(idx), .clr_on_rd(clr_on_rd), .valid_cont(a_valid), .data_cont(a_data),
        .ch_cont(a_ch), .rd_err(a_err), .overflow(a_ovf)
    );

    push_counter_bank #(.CH_SEL_WIDTH(2), .COUNT_MODE(0), .SATURATE(0)) dut_b (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .req(req),
        .idx(idx[1:0]), .clr_on_rd(clr_on_rd), .valid_cont(b_valid), .data_cont(b_data),
        .ch_cont(b_ch), .rd_err(b_err), .overflow(b_ovf)
    );

    push_counter_bank #(.CH_SEL_WIDTH(2), .COUNT_MODE(1), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .req(req),
        .idx(idx[1:0]), .clr_on_rd(clr_on_rd), .valid_cont(s_valid), .data_cont(s_data),
        .ch_cont(s_ch), .rd_err(s_err), .overflow(s_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input int c, input logic [7:0] d);
        push = 4'(1 << c);
        data_in[c*8 +: 8] = d;
        tick();
        push = '0;
    endtask

    task automatic read(input logic [2:0] i, input logic clr);
        req = 1'b1;
        idx = i;
        clr_on_rd = clr;
        tick();
        req = 1'b0;
        clr_on_rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        push = '0; data_in = '0; req = 1'b0; idx = '0; clr_on_rd = 1'b0;
        do_reset();
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_data", 32'(a_data), 32'd0);
        check("rst_ch", 32'(a_ch), 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        check("rst_ovf", 32'(a_ovf), 32'd0);

        // Change-count on ch0: 00 00 05 05 07 gives three events.
        push_one(0, 8'h00);
        push_one(0, 8'h00);
        push_one(0, 8'h05);
        push_one(0, 8'h05);
        push_one(0, 8'h07);
        check("pre_read_valid", 32'(a_valid), 32'd0);
        read(3'd0, 1'b0);
        check("chg_valid", 32'(a_valid), 32'd1);
        check("chg_data", 32'(a_data), 32'd3);
        check("chg_ch", 32'(a_ch), 32'd0);
        check("all_mode_ch0", 32'(b_data), 32'd5);
        tick();
        check("valid_pulse_end", 32'(a_valid), 32'd0);
        check("data_hold", 32'(a_data), 32'd3);

        // All four channels push together for ten cycles.
        do_reset();
        data_in = 32'h11223344;
        push = 4'hF;
        for (int k = 0; k < 10; k++) tick();
        push = '0;
        req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            idx = 3'(c);
            tick();
            check($sformatf("b2b_valid%0d", c), 32'(b_valid), 32'd1);
            check($sformatf("b2b_data%0d", c), 32'(b_data), 32'd10);
            check($sformatf("b2b_ch%0d", c), 32'(b_ch), 32'(c));
            check($sformatf("chg_const%0d", c), 32'(a_data), 32'd1);
        end
        req = 1'b0;
        tick();
        check("b2b_end", 32'(b_valid), 32'd0);

        // 256 distinct pushes on ch2: wrap vs saturate.
        do_reset();
        for (int k = 0; k < 256; k++) push_one(2, 8'(k));
        read(3'd2, 1'b0);
        check("wrap_data", 32'(a_data), 32'd0);
        check("wrap_ovf", 32'(a_ovf), 32'h4);
        check("sat_data", 32'(s_data), 32'd255);
        check("sat_ovf", 32'(s_ovf), 32'h4);

        // Clear-on-read in the same cycle as a counting push.
        push_one(1, 8'd1);
        push_one(1, 8'd2);
        push_one(1, 8'd3);
        push_one(1, 8'd4);
        push = 4'b0010;
        data_in[15:8] = 8'd9;
        read(3'd1, 1'b1);
        push = '0;
        check("clr_old_count", 32'(a_data), 32'd4);
        read(3'd1, 1'b0);
        check("clr_then_event", 32'(a_data), 32'd1);
        read(3'd2, 1'b1);
        check("clr_ovf_data", 32'(a_data), 32'd0);
        check("clr_ovf_flag", 32'(a_ovf), 32'h0);

        // Out-of-range index.
        read(3'd5, 1'b0);
        check("err_valid", 32'(a_valid), 32'd1);
        check("err_flag", 32'(a_err), 32'd1);
        check("err_data", 32'(a_data), 32'd0);
        check("err_ch", 32'(a_ch), 32'd5);
        read(3'd1, 1'b0);
        check("err_no_change", 32'(a_data), 32'd1);
        check("err_cleared", 32'(a_err), 32'd0);

        // Reset colliding with a read cancels the pulse.
        for (int k = 1; k <= 7; k++) push_one(3, 8'(k));
        read(3'd3, 1'b0);
        check("ch3_seven", 32'(a_data), 32'd7);
        tick();
        req = 1'b1;
        idx = 3'd3;
        reset = 1'b1;
        tick();
        req = 1'b0;
        reset = 1'b0;
        check("rst_read_valid", 32'(a_valid), 32'd0);
        check("rst_read_data", 32'(a_data), 32'd0);
        read(3'd3, 1'b0);
        check("after_rst_valid", 32'(a_valid), 32'd1);
        check("after_rst_ch3", 32'(a_data), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
